// File: rtl/coin_acceptor_front.sv
// Coin-slot front end: synchronizes and debounces four coin sensors, enforces
// per-denomination stack capacity, queues accepted coins and hands them to the
// changer as one-hot single-cycle insert pulses whenever the changer is idle.
module coin_acceptor_front #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_NICKELS     = 10,
    parameter int MAX_DIMES       = 5,
    parameter int MAX_QUARTERS    = 3,
    parameter int MAX_DOLLARS     = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       nickel_in,
    input  logic       dime_in,
    input  logic       quarter_in,
    input  logic       dollar_in,
    input  logic       busy,
    input  logic       clear_credit,
    output logic       nickel,
    output logic       dime,
    output logic       quarter,
    output logic       dollar,
    output logic       coin_reject,
    output logic [8:0] credit,
    output logic       fifo_full,
    output logic       fifo_empty
);

    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DB_ONE   = DW'(1);
    localparam logic [DW-1:0] DB_ZERO  = DW'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

    // Debounce FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ARMED = 2'b01;
    localparam logic [1:0] ST_HELD  = 2'b10;

    // Coin codes double as bit positions in the channel vectors
    localparam logic [1:0] CODE_NICKEL  = 2'd0;
    localparam logic [1:0] CODE_DIME    = 2'd1;
    localparam logic [1:0] CODE_QUARTER = 2'd2;
    localparam logic [1:0] CODE_DOLLAR  = 2'd3;

    function automatic logic [8:0] coin_value(input logic [1:0] code);
        case (code)
            CODE_NICKEL:  coin_value = 9'd5;
            CODE_DIME:    coin_value = 9'd10;
            CODE_QUARTER: coin_value = 9'd25;
            CODE_DOLLAR:  coin_value = 9'd100;
            default:      coin_value = 9'd0;
        endcase
    endfunction

    function automatic logic [7:0] coin_max(input logic [1:0] code);
        case (code)
            CODE_NICKEL:  coin_max = 8'(MAX_NICKELS);
            CODE_DIME:    coin_max = 8'(MAX_DIMES);
            CODE_QUARTER: coin_max = 8'(MAX_QUARTERS);
            CODE_DOLLAR:  coin_max = 8'(MAX_DOLLARS);
            default:      coin_max = 8'd0;
        endcase
    endfunction

    logic [3:0]    raw_s;
    logic [3:0]    sync_meta_r;
    logic [3:0]    sync_r;
    logic [3:0]    qualify_s;
    logic [3:0]    pending_r;
    logic [3:0]    grant_s;
    logic          sel_valid_s;
    logic [1:0]    sel_code_s;
    logic          accept_s;
    logic          reject_s;
    logic          pop_s;
    logic [7:0]    count_r [4];
    logic [1:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   fifo_cnt_r;
    logic [AW:0]   fifo_cnt_s;
    logic [1:0]    head_code_s;
    logic [3:0]    pulse_r;

    assign raw_s = {dollar_in, quarter_in, dime_in, nickel_in};

    // Two-flop synchronizer for the asynchronous sensor levels
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_meta_r <= 4'b0000;
            sync_r      <= 4'b0000;
        end else begin
            sync_meta_r <= raw_s;
            sync_r      <= sync_meta_r;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_db
        logic [1:0]    state_r;
        logic [1:0]    state_s;
        logic [DW-1:0] cnt_r;
        logic [DW-1:0] cnt_s;
        logic          hit_s;

        // Next-state logic: qualify after a stable-high run, re-arm only after a stable-low run
        always_comb begin
            state_s = state_r;
            cnt_s   = cnt_r;
            hit_s   = 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (sync_r[g]) begin
                        state_s = ST_ARMED;
                        cnt_s   = DB_ONE;
                    end else begin
                        cnt_s   = DB_ZERO;
                    end
                end
                ST_ARMED: begin
                    if (!sync_r[g]) begin
                        state_s = ST_IDLE;
                        cnt_s   = DB_ZERO;
                    end else if (cnt_r == DB_LAST) begin
                        state_s = ST_HELD;
                        cnt_s   = DB_ZERO;
                        hit_s   = 1'b1;
                    end else begin
                        cnt_s   = cnt_r + DB_ONE;
                    end
                end
                ST_HELD: begin
                    if (sync_r[g]) begin
                        cnt_s   = DB_ZERO;
                    end else if (cnt_r == DB_LAST) begin
                        state_s = ST_IDLE;
                        cnt_s   = DB_ZERO;
                    end else begin
                        cnt_s   = cnt_r + DB_ONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = DB_ZERO;
                end
            endcase
        end

        // Debounce state and run-length counter
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                state_r <= ST_IDLE;
                cnt_r   <= DB_ZERO;
            end else begin
                state_r <= state_s;
                cnt_r   <= cnt_s;
            end
        end

        assign qualify_s[g] = hit_s;
    end

    // Fixed-priority arbiter over pending coins; stalls during a credit clear
    always_comb begin
        grant_s     = 4'b0000;
        sel_valid_s = 1'b0;
        sel_code_s  = CODE_NICKEL;
        if (clear_credit) begin
            sel_valid_s = 1'b0;
        end else if (pending_r[3]) begin
            grant_s = 4'b1000; sel_valid_s = 1'b1; sel_code_s = CODE_DOLLAR;
        end else if (pending_r[2]) begin
            grant_s = 4'b0100; sel_valid_s = 1'b1; sel_code_s = CODE_QUARTER;
        end else if (pending_r[1]) begin
            grant_s = 4'b0010; sel_valid_s = 1'b1; sel_code_s = CODE_DIME;
        end else if (pending_r[0]) begin
            grant_s = 4'b0001; sel_valid_s = 1'b1; sel_code_s = CODE_NICKEL;
        end else begin
            sel_valid_s = 1'b0;
        end
    end

    // Accept/reject decision, emission enable and next queue occupancy
    always_comb begin
        accept_s    = sel_valid_s && (count_r[sel_code_s] < coin_max(sel_code_s))
                      && (fifo_cnt_r != CNT_FULL);
        reject_s    = sel_valid_s && !accept_s;
        pop_s       = !clear_credit && !busy && (fifo_cnt_r != CNT_ZERO);
        head_code_s = mem_r[rd_ptr_r];
        case ({accept_s, pop_s})
            2'b10:   fifo_cnt_s = fifo_cnt_r + CNT_ONE;
            2'b01:   fifo_cnt_s = fifo_cnt_r - CNT_ONE;
            default: fifo_cnt_s = fifo_cnt_r;
        endcase
    end

    // Pending flags: a granted flag clears, newly qualified coins set theirs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_r <= 4'b0000;
        end else begin
            pending_r <= (pending_r & ~grant_s) | qualify_s;
        end
    end

    // Accepted-coin queue; a credit clear flushes it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= CNT_ZERO;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 2'b00;
            end
        end else if (clear_credit) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= CNT_ZERO;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
        end else begin
            if (accept_s) begin
                mem_r[wr_ptr_r] <= sel_code_s;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            fifo_cnt_r <= fifo_cnt_s;
            fifo_full  <= (fifo_cnt_s == CNT_FULL);
            fifo_empty <= (fifo_cnt_s == CNT_ZERO);
        end
    end

    // Insert pulses, reject pulse, delivered credit and per-type stack counts
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pulse_r     <= 4'b0000;
            coin_reject <= 1'b0;
            credit      <= 9'd0;
            for (int i = 0; i < 4; i++) begin
                count_r[i] <= 8'd0;
            end
        end else if (clear_credit) begin
            pulse_r     <= 4'b0000;
            coin_reject <= (fifo_cnt_r != CNT_ZERO);
            credit      <= 9'd0;
            for (int i = 0; i < 4; i++) begin
                count_r[i] <= 8'd0;
            end
        end else begin
            pulse_r     <= pop_s ? (4'b0001 << head_code_s) : 4'b0000;
            coin_reject <= reject_s;
            if (pop_s) begin
                credit <= credit + coin_value(head_code_s);
            end
            if (accept_s) begin
                count_r[sel_code_s] <= count_r[sel_code_s] + 8'd1;
            end
        end
    end

    assign {dollar, quarter, dime, nickel} = pulse_r;

endmodule
